// File: rtl/operand_aligner_if.sv
// Operand/result bundle for operand_aligner: an accept-side handshake carrying
// the two operands and a result-side handshake carrying the aligned pair.
interface operand_aligner_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 28
);
  logic             in_valid;
  logic             in_ready;
  logic [EXP_W-1:0] exp_A;
  logic [EXP_W-1:0] exp_B;
  logic [MAN_W-1:0] mantis_A;
  logic [MAN_W-1:0] mantis_B;
  logic             out_valid;
  logic             out_ready;
  logic [EXP_W-1:0] exp_out;
  logic [MAN_W-1:0] mantis_big;
  logic [MAN_W-1:0] mantis_aligned;
  logic             swapped;

  modport master (
    output in_valid, exp_A, exp_B, mantis_A, mantis_B, out_ready,
    input  in_ready, out_valid, exp_out, mantis_big, mantis_aligned, swapped
  );

  modport slave (
    input  in_valid, exp_A, exp_B, mantis_A, mantis_B, out_ready,
    output in_ready, out_valid, exp_out, mantis_big, mantis_aligned, swapped
  );
endinterface

// File: rtl/operand_aligner.sv
// Multi-cycle exponent aligner: picks the larger operand and right-shifts the smaller
// mantissa by the exponent difference, STEP bits per cycle. Macro OPERAND_ALIGNER_STICKY_EN adds a sticky bit.
module operand_aligner #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 28,
  parameter int STEP  = 4
) (
  input  logic               clk,
  input  logic               rst,
  operand_aligner_if.slave   bus,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [EXP_W-1:0] STEP_E = EXP_W'(STEP);

  state_t           state_q, state_d;
  logic [EXP_W-1:0] rem_q, rem_d;
  logic [MAN_W-1:0] work_q, work_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [MAN_W-1:0] big_q, big_d;
  logic             swp_q, swp_d;

  logic             b_big;
  logic [EXP_W-1:0] exp_big, exp_small, diff, sh;
  logic [MAN_W-1:0] man_big, man_small, sat_val, step_res;

  // Operand selection: B wins on larger exponent, or equal exponent and larger mantissa.
  always_comb begin
    b_big     = (bus.exp_B > bus.exp_A) ||
                ((bus.exp_B == bus.exp_A) && (bus.mantis_B > bus.mantis_A));
    exp_big   = b_big ? bus.exp_B    : bus.exp_A;
    exp_small = b_big ? bus.exp_A    : bus.exp_B;
    man_big   = b_big ? bus.mantis_B : bus.mantis_A;
    man_small = b_big ? bus.mantis_A : bus.mantis_B;
    diff      = exp_big - exp_small;
`ifdef OPERAND_ALIGNER_STICKY_EN
    sat_val   = {{(MAN_W-1){1'b0}}, |man_small};
`else
    sat_val   = '0;
`endif
  end

  // One shift step of min(STEP, remaining) bits.
  always_comb begin
    sh       = (rem_q > STEP_E) ? STEP_E : rem_q;
    step_res = work_q >> sh;
`ifdef OPERAND_ALIGNER_STICKY_EN
    step_res[0] = step_res[0] | (|(work_q & ~({MAN_W{1'b1}} << sh)));
`endif
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // the producer holds its payload while valid is 1 and ready is 0.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    work_d  = work_q;
    exp_d   = exp_q;
    big_d   = big_q;
    swp_d   = swp_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          exp_d = exp_big;
          big_d = man_big;
          swp_d = b_big;
          if (diff == '0) begin
            work_d  = man_small;
            rem_d   = '0;
            state_d = DONE;
          end else if (32'(diff) >= MAN_W) begin
            work_d  = sat_val;
            rem_d   = '0;
            state_d = DONE;
          end else begin
            work_d  = man_small;
            rem_d   = diff;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_d = step_res;
        rem_d  = rem_q - sh;
        if (rem_q == sh) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      work_q  <= '0;
      exp_q   <= '0;
      big_q   <= '0;
      swp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      work_q  <= work_d;
      exp_q   <= exp_d;
      big_q   <= big_d;
      swp_q   <= swp_d;
    end
  end

  assign bus.in_ready       = (state_q == IDLE) && !rst;
  assign bus.out_valid      = (state_q == DONE);
  assign bus.exp_out        = exp_q;
  assign bus.mantis_big     = big_q;
  assign bus.mantis_aligned = work_q;
  assign bus.swapped        = swp_q;
  assign dbg_state          = state_q;

endmodule

// File: tb/tb_operand_aligner.sv
// Directed bench for operand_aligner (EXP_W=8, MAN_W=28, STEP=4); expectations
// follow OPERAND_ALIGNER_STICKY_EN when the bench is built with it.
module tb_operand_aligner;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;
  int         checks = 0;
  int         failures = 0;

`ifdef OPERAND_ALIGNER_STICKY_EN
  localparam logic [27:0] EXP_BASIC = 28'h0400001;
  localparam logic [27:0] EXP_EARLY = 28'h0000001;
`else
  localparam logic [27:0] EXP_BASIC = 28'h0400000;
  localparam logic [27:0] EXP_EARLY = 28'h0000000;
`endif

  operand_aligner_if #(.EXP_W(8), .MAN_W(28)) bus ();

  operand_aligner #(.EXP_W(8), .MAN_W(28), .STEP(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [27:0] ref_align(logic [27:0] x, int d);
    logic [27:0] r;
    if (d == 0) return x;
    if (d >= 28) begin
`ifdef OPERAND_ALIGNER_STICKY_EN
      return {27'b0, |x};
`else
      return 28'h0;
`endif
    end
    r = x >> d;
`ifdef OPERAND_ALIGNER_STICKY_EN
    r[0] = r[0] | (|(x & ((28'h1 << d) - 28'h1)));
`endif
    return r;
  endfunction

  function automatic int exp_lat(int d);
    return (d == 0 || d >= 28) ? 1 : 1 + (d + 3) / 4;
  endfunction

  // Drives one pair from IDLE and waits (bounded) for out_valid; leaves DUT in DONE.
  task automatic issue(input logic [7:0] ea, input logic [7:0] eb,
                       input logic [27:0] ma, input logic [27:0] mb, output int lat);
    bus.exp_A = ea; bus.exp_B = eb; bus.mantis_A = ma; bus.mantis_B = mb;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    checks++; if ({bus.exp_out, bus.mantis_big, bus.mantis_aligned, bus.swapped} !== 65'h0) begin
      failures++; $display("FAIL reset_data got=%h/%h/%h/%b exp=0", bus.exp_out, bus.mantis_big, bus.mantis_aligned, bus.swapped); end
    rst = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_basic_shift();
    int lat;
    issue(8'h85, 8'h80, 28'h8000000, 28'h800000F, lat);
    checks++; if (lat !== 3) begin failures++; $display("FAIL basic_latency got=%0d exp=3", lat); end
    checks++; if (bus.exp_out !== 8'h85) begin failures++; $display("FAIL basic_exp_out got=%h exp=85", bus.exp_out); end
    checks++; if (bus.swapped !== 1'b0) begin failures++; $display("FAIL basic_swapped got=%b exp=0", bus.swapped); end
    checks++; if (bus.mantis_big !== 28'h8000000) begin failures++; $display("FAIL basic_big got=%h exp=8000000", bus.mantis_big); end
    checks++; if (bus.mantis_aligned !== EXP_BASIC) begin failures++; $display("FAIL basic_aligned got=%h exp=%h", bus.mantis_aligned, EXP_BASIC); end
    release_result();
  endtask

  task automatic test_early_out();
    int lat;
    issue(8'h10, 8'h40, 28'h0000003, 28'h1234567, lat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL early_latency got=%0d exp=1", lat); end
    checks++; if (bus.swapped !== 1'b1) begin failures++; $display("FAIL early_swapped got=%b exp=1", bus.swapped); end
    checks++; if (bus.exp_out !== 8'h40) begin failures++; $display("FAIL early_exp_out got=%h exp=40", bus.exp_out); end
    checks++; if (bus.mantis_big !== 28'h1234567) begin failures++; $display("FAIL early_big got=%h exp=1234567", bus.mantis_big); end
    checks++; if (bus.mantis_aligned !== EXP_EARLY) begin failures++; $display("FAIL early_aligned got=%h exp=%h", bus.mantis_aligned, EXP_EARLY); end
    release_result();
  endtask

  task automatic test_equal_exp();
    int lat;
    issue(8'h7F, 8'h7F, 28'h0000100, 28'h0000200, lat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL equal_latency got=%0d exp=1", lat); end
    checks++; if (bus.swapped !== 1'b1) begin failures++; $display("FAIL equal_swapped got=%b exp=1", bus.swapped); end
    checks++; if (bus.mantis_big !== 28'h0000200) begin failures++; $display("FAIL equal_big got=%h exp=0000200", bus.mantis_big); end
    checks++; if (bus.mantis_aligned !== 28'h0000100) begin failures++; $display("FAIL equal_aligned got=%h exp=0000100", bus.mantis_aligned); end
    release_result();
    // Full tie keeps A as the larger operand.
    issue(8'h22, 8'h22, 28'h0ABCDEF, 28'h0ABCDEF, lat);
    checks++; if (bus.swapped !== 1'b0) begin failures++; $display("FAIL tie_swapped got=%b exp=0", bus.swapped); end
    checks++; if (bus.exp_out !== 8'h22) begin failures++; $display("FAIL tie_exp_out got=%h exp=22", bus.exp_out); end
    release_result();
  endtask

  task automatic test_hold();
    int lat;
    issue(8'h50, 8'h50, 28'h0000123, 28'h0000045, lat);
    bus.exp_A = 8'h30; bus.exp_B = 8'h32; bus.mantis_A = 28'h0000010; bus.mantis_B = 28'h0000007;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        failures++; $display("FAIL hold_handshake cycle=%0d got valid=%b ready=%b exp valid=1 ready=0", i, bus.out_valid, bus.in_ready); end
      checks++; if (bus.exp_out !== 8'h50 || bus.mantis_big !== 28'h0000123 || bus.mantis_aligned !== 28'h0000045 || bus.swapped !== 1'b0) begin
        failures++; $display("FAIL hold_data cycle=%0d got=%h/%h/%h/%b exp=50/0000123/0000045/0", i, bus.exp_out, bus.mantis_big, bus.mantis_aligned, bus.swapped); end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++; if (dbg_state !== 2'd0 || bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL hold_release got state=%0d ready=%b exp state=0 ready=1", dbg_state, bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat !== 2) begin failures++; $display("FAIL hold_next_latency got=%0d exp=2", lat); end
    checks++; if (bus.exp_out !== 8'h32 || bus.swapped !== 1'b1 || bus.mantis_big !== 28'h0000007 || bus.mantis_aligned !== 28'h0000004) begin
      failures++; $display("FAIL hold_next_data got=%h/%b/%h/%h exp=32/1/0000007/0000004", bus.exp_out, bus.swapped, bus.mantis_big, bus.mantis_aligned); end
    release_result();
  endtask

  task automatic test_reset_abort();
    int seen;
    bus.exp_A = 8'h54; bus.exp_B = 8'h40; bus.mantis_A = 28'h8000000; bus.mantis_B = 28'hFFFFFFF;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++; if (dbg_state !== 2'd1) begin failures++; $display("FAIL abort_in_shift got=%0d exp=1", dbg_state); end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL abort_ready_in_rst got=%b exp=0", bus.in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++; if (dbg_state !== 2'd0 || bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL abort_idle got state=%0d ready=%b exp state=0 ready=1", dbg_state, bus.in_ready); end
    checks++; if ({bus.exp_out, bus.mantis_big, bus.mantis_aligned, bus.swapped} !== 65'h0) begin
      failures++; $display("FAIL abort_data got=%h/%h/%h/%b exp=0", bus.exp_out, bus.mantis_big, bus.mantis_aligned, bus.swapped); end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL abort_no_result got=%0d valid cycles exp=0", seen); end
  endtask

  task automatic test_sweep();
    int lat;
    logic [27:0] exp_man;
    for (int d = 0; d <= 30; d++) begin
      issue(8'(8'h20 + d), 8'h20, 28'hFFFFFFF, 28'hFFFFFFF, lat);
      exp_man = ref_align(28'hFFFFFFF, d);
      checks++; if (lat !== exp_lat(d)) begin failures++; $display("FAIL sweep_latency d=%0d got=%0d exp=%0d", d, lat, exp_lat(d)); end
      checks++; if (bus.mantis_aligned !== exp_man) begin failures++; $display("FAIL sweep_aligned d=%0d got=%h exp=%h", d, bus.mantis_aligned, exp_man); end
      checks++; if (bus.exp_out !== 8'(8'h20 + d) || bus.swapped !== 1'b0 || bus.mantis_big !== 28'hFFFFFFF) begin
        failures++; $display("FAIL sweep_big d=%0d got=%h/%b/%h exp=%h/0/FFFFFFF", d, bus.exp_out, bus.swapped, bus.mantis_big, 8'(8'h20 + d)); end
      release_result();
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.exp_A = '0; bus.exp_B = '0; bus.mantis_A = '0; bus.mantis_B = '0;
    test_reset();
    test_basic_shift();
    test_early_out();
    test_equal_exp();
    test_hold();
    test_reset_abort();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/operand_aligner.md
OPERAND_ALIGNER -- requirements
Module: operand_aligner

Interface
REQ-001 Parameter EXP_W, default 8: exponent width in bits.
REQ-002 Parameter MAN_W, default 28: mantissa width in bits, including guard bits.
REQ-003 Parameter STEP, default 4: maximum right-shift distance per cycle; legal range 1..MAN_W.
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 rst  input  1: reset, synchronous, active-high.
REQ-006 in_valid  input  1: operand pair present.
REQ-007 in_ready  output  1: block can accept an operand pair.
REQ-008 exp_A, exp_B  input  EXP_W: operand exponents.
REQ-009 mantis_A, mantis_B  input  MAN_W: operand mantissas.
REQ-010 out_valid  output  1: aligned result present.
REQ-011 out_ready  input  1: downstream accepts the result.
REQ-012 exp_out  output  EXP_W: exponent of the larger operand.
REQ-013 mantis_big  output  MAN_W: mantissa of the larger operand, unshifted.
REQ-014 mantis_aligned  output  MAN_W: mantissa of the smaller operand, right-shifted by the exponent difference.
REQ-015 swapped  output  1: set when operand B was selected as the larger operand.

Function
REQ-016 The block SHALL implement states IDLE, SHIFT and DONE; in_ready SHALL be 1 only in IDLE while rst=0.
REQ-017 Acceptance SHALL occur on the edge where in_valid=1 and in_ready=1; all inputs are sampled on that edge only.
REQ-018 Selection: B SHALL be the larger operand if exp_B>exp_A, or if exp_B==exp_A and mantis_B>mantis_A; otherwise A is larger (full tie gives swapped=0).
REQ-019 diff SHALL be exp_big-exp_small, unsigned, EXP_W bits, never negative.
REQ-020 On acceptance: if diff==0, next state SHALL be DONE with mantis_aligned = the small mantissa.
REQ-021 On acceptance: if diff>=MAN_W, next state SHALL be DONE with the saturated result per REQ-030/REQ-031 (early out).
REQ-022 On acceptance, otherwise: next state SHALL be SHIFT, with remaining=diff and the working register holding the small mantissa.
REQ-023 Each SHIFT cycle SHALL shift the working register right by min(STEP, remaining) and decrement remaining by the same amount; when remaining reaches 0, state SHALL become DONE.
REQ-024 Latency from the acceptance edge to out_valid=1 SHALL be 1 cycle for diff==0 or diff>=MAN_W, else 1+ceil(diff/STEP) cycles.
REQ-025 In DONE, out_valid SHALL be 1, and all outputs SHALL be held stable until out_ready=1; on that edge, state SHALL return to IDLE.
REQ-026 in_valid SHALL be ignored outside IDLE; there is no back-to-back acceptance, so the minimum issue interval is latency+1 cycles.
REQ-027 exp_out, mantis_big and swapped SHALL be registered at acceptance and SHALL remain constant through SHIFT and DONE.

Reset
REQ-028 While rst=1 at an edge: state SHALL go to IDLE, remaining to 0, and all data outputs, out_valid and swapped to 0.
REQ-029 in_ready SHALL be 0 while rst=1. Reset in SHIFT or DONE SHALL abort the operation with no result delivered; in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-030 With macro OPERAND_ALIGNER_STICKY_EN defined, every shift step SHALL OR all bits shifted out into bit 0 of the working register. A saturated result SHALL be {MAN_W-1 zeros, OR of all bits of the small mantissa}.
REQ-031 Without OPERAND_ALIGNER_STICKY_EN, shifting SHALL be a plain logical right shift with shifted-out bits discarded, and a saturated result SHALL be all zeros.

Verification (MAN_W=28, EXP_W=8, STEP=4)
REQ-032 exp_A=0x85, exp_B=0x80, mantis_A=0x8000000, mantis_B=0x800000F -> out_valid 3 cycles after acceptance, exp_out=0x85, swapped=0, mantis_big=0x8000000, mantis_aligned=0x0400001 (STICKY_EN) / 0x0400000 (no macro).
REQ-033 exp_A=0x10, exp_B=0x40, mantis_A=0x0000003, mantis_B=0x1234567 -> swapped=1, exp_out=0x40, mantis_big=0x1234567, latency 1, mantis_aligned=0x0000001 (STICKY_EN) / 0x0000000 (no macro).
REQ-034 exp_A=exp_B=0x7F, mantis_A=0x0000100, mantis_B=0x0000200 -> swapped=1, mantis_big=0x0000200, mantis_aligned=0x0000100, latency 1.
REQ-035 Result in DONE with out_ready held 0 for 5 cycles while in_valid=1 with new operands -> outputs stable, in_ready=0, no acceptance; out_ready=1 -> IDLE, then the next pair is accepted.
REQ-036 rst=1 for one edge during SHIFT with diff=20 -> next cycle state IDLE, outputs 0, out_valid never asserted for the aborted pair, in_ready=1.
REQ-037 Sweep diff=0..30 with mantis_small=0xFFFFFFF -> latency matches REQ-024 and mantis_aligned matches the reference shift with or without sticky, in both macro builds.
